// File: rtl/code_pattern_datapath_pkg.sv
// Shared defaults, word/address types and a width helper for the code pattern datapath.
`default_nettype none

package code_pattern_datapath_pkg;

  localparam int C_CODE_W    = 8;
  localparam int C_ADDR_W    = 4;
  localparam int C_N_CODES   = 10;
  localparam int C_ROM_LAT   = 2;
  localparam int C_BIT_TICKS = 4;

  typedef logic [C_CODE_W-1:0] code_t;
  typedef logic [C_ADDR_W-1:0] addr_t;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_pattern_datapath_bit_serializer.sv
// MSB-first shifter: holds each bit for BIT_TICKS advance cycles and flags the last tick of the word.
`default_nettype none

module bit_serializer
  import code_pattern_datapath_pkg::*;
#(
  parameter int CODE_W    = C_CODE_W,
  parameter int BIT_TICKS = C_BIT_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_ser_out,
  output logic              o_done_gen
);

  localparam int BC_W = clog2_min1(CODE_W);
  localparam int TK_W = clog2_min1(BIT_TICKS);

  logic [CODE_W-1:0] r_sreg;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [TK_W-1:0]   r_tick_cnt;
  logic              w_last_tick;

  assign w_last_tick = (r_tick_cnt == TK_W'(BIT_TICKS - 1));
  assign o_done_gen  = i_adv & w_last_tick & (r_bit_cnt == '0);
  // Follows the register even while paused, so a gap just stretches the current bit.
  assign o_ser_out   = r_sreg[CODE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (i_clear) begin
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (i_load) begin
      r_sreg     <= i_code;
      r_bit_cnt  <= BC_W'(CODE_W - 1);
      r_tick_cnt <= '0;
    end else if (i_adv) begin
      if (w_last_tick) begin
        r_tick_cnt <= '0;
        r_sreg     <= {r_sreg[CODE_W-2:0], 1'b0};
        r_bit_cnt  <= r_bit_cnt - BC_W'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + TK_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_pattern_datapath.sv
// Datapath under FSM enables: ROM word fetch, serial pattern output, address walk and XOR checksum display.
`default_nettype none

module code_pattern_datapath
  import code_pattern_datapath_pkg::*;
#(
  parameter int CODE_W    = C_CODE_W,
  parameter int ADDR_W    = C_ADDR_W,
  parameter int N_CODES   = C_N_CODES,
  parameter int ROM_LAT   = C_ROM_LAT,
  parameter int BIT_TICKS = C_BIT_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init_data_ena,
  input  logic              i_read_cod_ena,
  input  logic              i_init_cnt_ena,
  input  logic              i_count_ena,
  input  logic              i_sw_led_ena,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_rd,
  input  logic [CODE_W-1:0] i_rom_data,
  output logic              o_done_cod,
  output logic              o_done_gen,
  output logic              o_done_fin,
  output logic              o_ser_out,
  output logic [CODE_W-1:0] o_led
);

  localparam int LAT_W = clog2_min1(ROM_LAT + 1);
  localparam int AF_W  = ADDR_W + 1;

  // One extra address bit so N_CODES == 2**ADDR_W is still reachable.
  logic [AF_W-1:0]   r_addr;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_csum;
  logic [CODE_W-1:0] r_led;

  logic w_rd_sel;
  logic w_load;
  logic w_adv;
  logic w_led_sel;
  logic w_capture;
  logic w_done_gen;
  logic w_done_fin;

  assign w_rd_sel  = i_read_cod_ena & ~i_init_data_ena;
  assign w_load    = i_init_cnt_ena & ~i_init_data_ena & ~i_read_cod_ena;
  assign w_adv     = i_count_ena & ~i_init_data_ena & ~i_read_cod_ena & ~i_init_cnt_ena;
  assign w_led_sel = i_sw_led_ena & ~i_init_data_ena & ~i_read_cod_ena
                     & ~i_init_cnt_ena & ~i_count_ena;

  assign w_capture  = w_rd_sel & (r_lat_cnt == LAT_W'(ROM_LAT));
  assign w_done_fin = (r_addr == AF_W'(N_CODES));

  assign o_rom_rd   = w_rd_sel & (r_lat_cnt == '0);
  assign o_done_cod = w_capture;
  assign o_done_gen = w_done_gen;
  assign o_done_fin = w_done_fin;
  assign o_rom_addr = r_addr[ADDR_W-1:0];
  assign o_led      = r_led;

  // Any cycle without read_cod_ena (including a higher-priority enable) abandons a pending read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (w_rd_sel) begin
      r_lat_cnt <= w_capture ? '0 : r_lat_cnt + LAT_W'(1);
    end else begin
      r_lat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
      r_csum <= '0;
    end else if (w_capture) begin
      r_code <= i_rom_data;
      r_csum <= r_csum ^ i_rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_done_gen && !w_done_fin) begin
      r_addr <= r_addr + AF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_sel ? r_csum : '0;
    end
  end

  bit_serializer #(
    .CODE_W    (CODE_W),
    .BIT_TICKS (BIT_TICKS)
  ) u_bit_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (i_init_data_ena),
    .i_load     (w_load),
    .i_adv      (w_adv),
    .i_code     (r_code),
    .o_ser_out  (o_ser_out),
    .o_done_gen (w_done_gen)
  );

endmodule

`default_nettype wire

// File: tb/tb_code_pattern_datapath.sv
// Scoreboard bench for code_pattern_datapath driving FSM-style enable sequences against a latency-2 ROM model.
`default_nettype none

module tb_code_pattern_datapath;
  import code_pattern_datapath_pkg::*;

  localparam int NC = 3;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  init_data_ena, read_cod_ena, init_cnt_ena, count_ena, sw_led_ena;
  addr_t rom_addr;
  logic  rom_rd;
  code_t rom_data;
  logic  done_cod, done_gen, done_fin, ser_out;
  code_t led;

  code_t rom [16];
  code_t p1 = '0;
  code_t p2 = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  code_pattern_datapath #(
    .N_CODES (NC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_init_data_ena (init_data_ena),
    .i_read_cod_ena  (read_cod_ena),
    .i_init_cnt_ena  (init_cnt_ena),
    .i_count_ena     (count_ena),
    .i_sw_led_ena    (sw_led_ena),
    .o_rom_addr      (rom_addr),
    .o_rom_rd        (rom_rd),
    .i_rom_data      (rom_data),
    .o_done_cod      (done_cod),
    .o_done_gen      (done_gen),
    .o_done_fin      (done_fin),
    .o_ser_out       (ser_out),
    .o_led           (led)
  );

  // ROM with two-cycle read latency; data only appears for a strobed address.
  always @(posedge clk) begin
    p1 <= rom_rd ? rom[rom_addr] : '0;
    p2 <= p1;
  end
  assign rom_data = p2;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && count_ena) begin
      if (exp_q.size() == 0) check_value("ser_q_underflow", 32'(exp_q.size()), 32'd1);
      else                   check_value("ser_out", 32'(ser_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init_data(input logic exp_fin);
    init_data_ena = 1'b1;
    @(negedge clk);
    check_value("done_fin", 32'(done_fin), 32'(exp_fin));
    next_cycle();
    init_data_ena = 1'b0;
  endtask

  task automatic do_read(input code_t expw);
    read_cod_ena = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_value("rom_rd", 32'(rom_rd), 32'(i == 1));
      check_value("done_cod", 32'(done_cod), 32'(i == 3));
      if (i == 3) check_value("rom_word", 32'(rom_data), 32'(expw));
      next_cycle();
    end
    read_cod_ena = 1'b0;
  endtask

  task automatic do_init_cnt();
    init_cnt_ena = 1'b1;
    next_cycle();
    init_cnt_ena = 1'b0;
  endtask

  task automatic do_count(input code_t code, input int gap_at, input int gap_len);
    for (int k = 0; k < C_CODE_W * C_BIT_TICKS; k++) begin
      if (k == gap_at) begin
        count_ena = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check_value("gap_ser_hold", 32'(ser_out), 32'(code[C_CODE_W-1 - k/C_BIT_TICKS]));
          check_value("gap_done_gen", 32'(done_gen), 32'd0);
          next_cycle();
        end
      end
      exp_q.push_back(code[C_CODE_W-1 - k/C_BIT_TICKS]);
      count_ena = 1'b1;
      @(negedge clk);
      check_value("done_gen", 32'(done_gen), 32'(k == C_CODE_W*C_BIT_TICKS - 1));
      next_cycle();
    end
    count_ena = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {init_data_ena, read_cod_ena, init_cnt_ena, count_ena, sw_led_ena} = '0;
    for (int i = 0; i < 16; i++) rom[i] = code_t'(8'h11 * i);
    rom[0] = 8'hA5;
    rom[1] = 8'hF0;
    rom[2] = 8'h3C;
    rom[3] = 8'hF0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_rom_rd", 32'(rom_rd), 32'd0);
    check_value("rst_done_cod", 32'(done_cod), 32'd0);
    check_value("rst_done_gen", 32'(done_gen), 32'd0);
    check_value("rst_done_fin", 32'(done_fin), 32'd0);
    check_value("rst_ser_out", 32'(ser_out), 32'd0);
    check_value("rst_led", 32'(led), 32'd0);
    check_value("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Word 0: plain fetch and serialisation
    do_init_data(1'b0);
    do_read(8'hA5);
    do_init_cnt();
    do_count(8'hA5, -1, 0);
    check_value("addr_after_w0", 32'(rom_addr), 32'd1);

    // Aborted read leaves the captured word untouched
    do_init_data(1'b0);
    read_cod_ena = 1'b1;
    @(negedge clk);
    check_value("abort_rom_rd", 32'(rom_rd), 32'd1);
    next_cycle();
    read_cod_ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_value("abort_done_cod", 32'(done_cod), 32'd0);
      check_value("abort_rom_rd_idle", 32'(rom_rd), 32'd0);
      next_cycle();
    end
    do_init_cnt();
    do_count(8'hA5, -1, 0);
    check_value("addr_after_abort", 32'(rom_addr), 32'd2);

    // Fresh read, then a 3-cycle gap mid-bit
    do_read(8'h3C);
    do_init_cnt();
    do_count(8'h3C, 9, 3);
    check_value("addr_at_end", 32'(rom_addr), 32'd3);
    do_init_data(1'b1);

    // Counting past the end must not move the address
    for (int k = 0; k < 2 * C_BIT_TICKS; k++) begin
      exp_q.push_back(1'b0);
      count_ena = 1'b1;
      @(negedge clk);
      check_value("sat_done_gen", 32'(done_gen), 32'(k == C_BIT_TICKS - 1));
      next_cycle();
    end
    count_ena = 1'b0;
    check_value("sat_addr", 32'(rom_addr), 32'd3);
    check_value("sat_done_fin", 32'(done_fin), 32'd1);

    // Checksum display: A5 ^ 3C
    sw_led_ena = 1'b1;
    next_cycle();
    sw_led_ena = 1'b0;
    @(negedge clk);
    check_value("led_csum", 32'(led), 32'h99);
    next_cycle();
    check_value("led_off", 32'(led), 32'd0);
    sw_led_ena = 1'b1;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_led", 32'(led), 32'd0);
    check_value("async_rst_addr", 32'(rom_addr), 32'd0);
    check_value("async_rst_done_fin", 32'(done_fin), 32'd0);
    sw_led_ena = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Reset in the 5th count cycle
    do_init_data(1'b0);
    do_read(8'hA5);
    do_init_cnt();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(rom[0][C_CODE_W-1 - k/C_BIT_TICKS]);
      count_ena = 1'b1;
      @(negedge clk);
      if (k < 4) next_cycle();
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_value("midrst_ser_out", 32'(ser_out), 32'd0);
    check_value("midrst_addr", 32'(rom_addr), 32'd0);
    check_value("midrst_done_gen", 32'(done_gen), 32'd0);
    check_value("midrst_done_cod", 32'(done_cod), 32'd0);
    check_value("midrst_done_fin", 32'(done_fin), 32'd0);
    check_value("midrst_led", 32'(led), 32'd0);
    count_ena = 1'b0;
    exp_q.delete();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Full loop over three words
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'h04;
    for (int w = 0; w < NC; w++) begin
      do_init_data(1'b0);
      do_read(rom[w]);
      do_init_cnt();
      do_count(rom[w], -1, 0);
      check_value("loop_addr", 32'(rom_addr), 32'(w + 1));
    end
    do_init_data(1'b1);
    sw_led_ena = 1'b1;
    next_cycle();
    sw_led_ena = 1'b0;
    @(negedge clk);
    check_value("loop_led", 32'(led), 32'h07);
    next_cycle();

    check_value("ser_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
